alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Registered ALU control and multi-cycle issue sequencer for the execute stage. Decodes the D/X instruction into ALU op, shift amount, sign-extend select and branch flag. Registers these into the X stage. Sequences multiply/divide instructions through a parametrised-latency busy window, stalling the pipeline until the result is due. It replaces the purely combinational ALU-control decode, adding configurable mult/div latency, a stall/done handshake and flush support.

## Interface
- OPW, 5: ALU op / shamt field width (instruction fields stay at fixed bit positions; OPW only sizes outputs, must be 5)
- MULT_CYCLES, 32: busy cycles for mult, legal range 1..255
- DIV_CYCLES, 32: busy cycles for div, legal range 1..255
- CNT_W, 8: busy counter width, must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- dx_ir  in  32  D/X instruction register
- dx_valid  in  1  dx_ir holds a live instruction
- flush  in  1  squash current instruction (branch mispredict / exception)
- alu_op  out  OPW  registered ALU op for X stage
- sham  out  OPW  registered shift amount
- sx_sel  out  1  registered immediate-select (1 = sign-extended immediate)
- is_branch  out  1  registered branch flag
- md_start  out  1  one-cycle pulse: launch multdiv unit
- md_is_div  out  1  operation of current/last launch (0 mult, 1 div)
- md_done  out  1  one-cycle pulse: multdiv result valid this cycle
- stall  out  1  hold F/D/DX stages this cycle (combinational)

## Operation
- Fields: opcode = dx_ir[31:27], func = dx_ir[6:2], shamt = dx_ir[11:7].
- Classes:
  - multdiv = opcode==0 and func in {6, 7} (6 mult, 7 div)
  - branch = opcode in {2, 6}
  - alu = opcode==0 and not multdiv
- Next-decode values:
  - alu_op = func if alu, 1 (subtract) if branch, else 0
  - sham = shamt if opcode==0, else 0
  - sx_sel = opcode!=0
  - is_branch = branch
- Decode registers load when stall==0. When dx_valid==0 or flush==1, they load all-zero (bubble).
- FSM states: IDLE, BUSY, DONE.
  - IDLE:
    - issue = dx_valid & multdiv & !flush
    - On issue: go to BUSY, load cnt = (div ? DIV_CYCLES : MULT_CYCLES), latch md_is_div, pulse md_start in the next cycle (first BUSY cycle).
    - Otherwise stay in IDLE.
  - BUSY: cnt decrements each cycle. After cnt decrements to 0, go to DONE.
  - DONE: md_done=1 for exactly one cycle, stall=0, then IDLE unconditionally. The instruction advances at the end of DONE; decode registers capture the multdiv instruction (alu_op=0) in that edge.
- stall = (IDLE & issue) | (BUSY & !flush).
- Flush in BUSY: next state IDLE, no md_done, counter cleared. Flush in DONE: ignored for the FSM (result already produced); decode registers load a bubble.
- Back-to-back multdiv: the second instruction is seen in IDLE the cycle after DONE and starts a new window normally.
- Reset values: state=IDLE, cnt=0, all outputs 0 (alu_op, sham, sx_sel, is_branch, md_start, md_is_div, md_done, stall).
- Reset mid-BUSY returns to IDLE immediately, with no md_done.

## Timing
- Non-multdiv: zero stall. Decode outputs are valid one cycle after dx_ir is presented (single register stage).
- Multdiv with latency N (issue cycle = cycle 0):
  - cycle 0: stall=1
  - cycles 1..N: BUSY, stall=1; md_start=1 in cycle 1 only
  - cycle N+1: DONE, md_done=1, stall=0
  - Total stall: N+1 cycles.
- md_start and md_done are never asserted in the same cycle.
- md_is_div is stable from cycle 1 through DONE.
- All outputs except stall are registered.

## Test plan
- Reset: hold reset_n=0 with dx_ir=random -> all outputs 0, state IDLE; release with dx_valid=0 -> outputs stay 0.
- ALU decode: dx_ir opcode 0, func 3, shamt 9 -> next cycle alu_op=3, sham=9, sx_sel=0, is_branch=0, stall never 1. Then opcode 2 -> alu_op=1, sham=0, sx_sel=1, is_branch=1.
- Mult, MULT_CYCLES=4: issue at cycle 0 -> stall=1 in cycles 0-4, md_start only in cycle 1, md_is_div=0, md_done in cycle 5 with stall=0, IDLE in cycle 6.
- Div then mult back-to-back, DIV_CYCLES=3, MULT_CYCLES=2: div done at cycle 4, mult issues at cycle 5 -> md_start cycle 6 with md_is_div=0, md_done cycle 8.
- Flush during BUSY: mult, flush=1 in cycle 2 -> stall=0 in cycle 2, IDLE in cycle 3, md_done never asserted, decode registers load a bubble.
- Async reset mid-BUSY: reset_n low in cycle 2 (between edges) -> outputs 0 immediately, no md_done after release.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Execute-stage ALU control decode with a registered X-stage copy, plus a
// fixed-latency mult/div issue sequencer that stalls the front end until the result is due.
module alu_issue_ctrl #(
   parameter int OPW         = 5,
   parameter int MULT_CYCLES = 32,
   parameter int DIV_CYCLES  = 32,
   parameter int CNT_W       = 8
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic [31:0]     dx_ir,
   input  logic            dx_valid,
   input  logic            flush,
   output logic [OPW-1:0]  alu_op,
   output logic [OPW-1:0]  sham,
   output logic            sx_sel,
   output logic            is_branch,
   output logic            md_start,
   output logic            md_is_div,
   output logic            md_done,
   output logic            stall
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_next;
   logic               r_md_start;
   logic               r_md_done;
   logic               r_md_is_div;
   logic               w_start_next;
   logic               w_done_next;
   logic               w_div_next;
   logic               w_stall_core;

   logic [OPW-1:0]     r_alu_op;
   logic [OPW-1:0]     r_sham;
   logic               r_sx_sel;
   logic               r_is_branch;

   logic [4:0]         w_opcode;
   logic [4:0]         w_func;
   logic [4:0]         w_shamt;
   logic               w_multdiv;
   logic               w_is_div;
   logic               w_branch;
   logic               w_alu;
   logic               w_issue;
   logic [OPW-1:0]     w_alu_op_d;
   logic [OPW-1:0]     w_sham_d;
   logic               w_unused;

   assign w_opcode   = dx_ir[31:27];
   assign w_func     = dx_ir[6:2];
   assign w_shamt    = dx_ir[11:7];
   assign w_unused   = ^{dx_ir[26:12], dx_ir[1:0]};

   assign w_multdiv  = (w_opcode == 5'd0) && ((w_func == 5'd6) || (w_func == 5'd7));
   assign w_is_div   = (w_func == 5'd7);
   assign w_branch   = (w_opcode == 5'd2) || (w_opcode == 5'd6);
   assign w_alu      = (w_opcode == 5'd0) && !w_multdiv;
   assign w_issue    = dx_valid && w_multdiv && !flush;

   assign w_alu_op_d = w_alu    ? OPW'(w_func) :
                       w_branch ? OPW'(1)      : '0;
   assign w_sham_d   = (w_opcode == 5'd0) ? OPW'(w_shamt) : '0;

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_stall_core = 1'b0;
      w_start_next = 1'b0;
      w_done_next  = 1'b0;
      w_div_next   = r_md_is_div;
      case (r_state)
         ST_IDLE: begin
            if (w_issue) begin
               w_state_next = ST_BUSY;
               w_cnt_next   = w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
               w_stall_core = 1'b1;
               w_start_next = 1'b1;
               w_div_next   = w_is_div;
            end
         end
         ST_BUSY: begin
            if (flush) begin
               // Squashed: abandon the window silently, no result pulse.
               w_state_next = ST_IDLE;
               w_cnt_next   = '0;
            end else begin
               w_stall_core = 1'b1;
               if (r_cnt <= CNT_W'(1)) begin
                  w_state_next = ST_DONE;
                  w_cnt_next   = '0;
                  w_done_next  = 1'b1;
               end else begin
                  w_cnt_next   = r_cnt - CNT_W'(1);
               end
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_md_start  <= 1'b0;
         r_md_done   <= 1'b0;
         r_md_is_div <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_md_start  <= w_start_next;
         r_md_done   <= w_done_next;
         r_md_is_div <= w_div_next;
      end
   end

   // Decode registers advance only when the pipeline moves; dead or squashed slots become bubbles.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_alu_op    <= '0;
         r_sham      <= '0;
         r_sx_sel    <= 1'b0;
         r_is_branch <= 1'b0;
      end else if (!w_stall_core) begin
         if (!dx_valid || flush) begin
            r_alu_op    <= '0;
            r_sham      <= '0;
            r_sx_sel    <= 1'b0;
            r_is_branch <= 1'b0;
         end else begin
            r_alu_op    <= w_alu_op_d;
            r_sham      <= w_sham_d;
            r_sx_sel    <= (w_opcode != 5'd0);
            r_is_branch <= w_branch;
         end
      end
   end

   assign alu_op    = r_alu_op;
   assign sham      = r_sham;
   assign sx_sel    = r_sx_sel;
   assign is_branch = r_is_branch;
   assign md_start  = r_md_start;
   assign md_is_div = r_md_is_div;
   assign md_done   = r_md_done;
   assign stall     = reset_n & w_stall_core;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: a timeline model pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_alu_issue_ctrl;

   localparam int MC = 4;
   localparam int DC = 3;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] dx_ir = '0;
   logic        dx_valid = 1'b0;
   logic        flush = 1'b0;
   logic [4:0]  alu_op, sham;
   logic        sx_sel, is_branch, md_start, md_is_div, md_done, stall;

   alu_issue_ctrl #(
      .OPW(5), .MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(8)
   ) dut (
      .clock(clock), .reset_n(reset_n), .dx_ir(dx_ir), .dx_valid(dx_valid), .flush(flush),
      .alu_op(alu_op), .sham(sham), .sx_sel(sx_sel), .is_branch(is_branch),
      .md_start(md_start), .md_is_div(md_is_div), .md_done(md_done), .stall(stall)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [4:0] alu_op;
      logic [4:0] sham;
      logic       sx, br, start, isdiv, done, stall;
      int         cyc;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: window described by absolute issue cycle and latency.
   int         cyc = 0;
   int         win_issue = -1;
   int         win_n = 0;
   logic       m_div = 1'b0;
   logic [4:0] m_alu = '0, m_sham = '0;
   logic       m_sx = 1'b0, m_br = 1'b0;
   logic       prev_stall = 1'b0;

   function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [4:0] fn, input logic [4:0] sh);
      logic [31:0] r;
      r = $urandom;
      r[31:27] = op;
      r[11:7]  = sh;
      r[6:2]   = fn;
      return r;
   endfunction

   task automatic model_reset();
      win_issue  = -1;
      m_div      = 1'b0;
      m_alu      = '0;
      m_sham     = '0;
      m_sx       = 1'b0;
      m_br       = 1'b0;
      prev_stall = 1'b0;
   endtask

   task automatic push_zero();
      exp_t e;
      e = '{alu_op: 5'd0, sham: 5'd0, sx: 1'b0, br: 1'b0, start: 1'b0,
            isdiv: 1'b0, done: 1'b0, stall: 1'b0, cyc: cyc};
      sb_q.push_back(e);
      cyc++;
   endtask

   task automatic step(input logic rst, input logic v, input logic [31:0] ir, input logic fl);
      exp_t       e;
      int         k;
      logic [4:0] op, fn;
      logic       md, st, brn;
      @(posedge clock);
      #1;
      reset_n  = rst;
      dx_valid = v;
      dx_ir    = ir;
      flush    = fl;
      if (!rst) begin
         model_reset();
         push_zero();
      end else begin
         k  = (win_issue < 0) ? 0 : cyc - win_issue;
         op = ir[31:27];
         fn = ir[6:2];
         md = (op == 5'd0) && (fn == 5'd6 || fn == 5'd7);
         if (win_issue < 0)   st = v && md && !fl;
         else if (k <= win_n) st = !fl;
         else                 st = 1'b0;
         e.alu_op = m_alu;
         e.sham   = m_sham;
         e.sx     = m_sx;
         e.br     = m_br;
         e.isdiv  = m_div;
         e.start  = (win_issue >= 0) && (k == 1);
         e.done   = (win_issue >= 0) && (k == win_n + 1);
         e.stall  = st;
         e.cyc    = cyc;
         sb_q.push_back(e);
         if (win_issue < 0) begin
            if (st) begin
               win_issue = cyc;
               win_n     = (fn == 5'd7) ? DC : MC;
               m_div     = (fn == 5'd7);
            end
         end else if (k <= win_n) begin
            if (fl) win_issue = -1;
         end else begin
            win_issue = -1;
         end
         if (!st) begin
            brn = (op == 5'd2) || (op == 5'd6);
            if (!v || fl) begin
               m_alu = '0; m_sham = '0; m_sx = 1'b0; m_br = 1'b0;
            end else begin
               m_alu  = (op == 5'd0 && !md) ? fn : (brn ? 5'd1 : 5'd0);
               m_sham = (op == 5'd0) ? ir[11:7] : 5'd0;
               m_sx   = (op != 5'd0);
               m_br   = brn;
            end
         end
         prev_stall = st;
         cyc++;
      end
   endtask

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req, input int c);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, c, act, req);
      end
   endtask

   // Reset asserted between edges while a window is in flight.
   task automatic rst_mid();
      @(posedge clock);
      #1;
      model_reset();
      push_zero();
      #2;
      reset_n = 1'b0;
      #1;
      cmp("async_rst_outputs",
          {alu_op, sham, sx_sel, is_branch, md_start, md_is_div, md_done, stall}, 32'd0, cyc - 1);
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         cmp("alu_op",    alu_op,    e.alu_op, e.cyc);
         cmp("sham",      sham,      e.sham,   e.cyc);
         cmp("sx_sel",    sx_sel,    e.sx,     e.cyc);
         cmp("is_branch", is_branch, e.br,     e.cyc);
         cmp("md_start",  md_start,  e.start,  e.cyc);
         cmp("md_is_div", md_is_div, e.isdiv,  e.cyc);
         cmp("md_done",   md_done,   e.done,   e.cyc);
         cmp("stall",     stall,     e.stall,  e.cyc);
         if (md_done)
            $display("txn: md_done at cycle %0d, is_div=%0d", e.cyc, md_is_div);
      end
   end

   initial begin
      logic [31:0] ir;
      logic [31:0] cur_ir;
      logic        cur_v;
      logic [4:0]  op, fn;
      int          r;

      // Reset held with live random instructions, then released idle.
      repeat (3) step(1'b0, 1'b1, mk_ir(5'd0, 5'd6, 5'd1), 1'b0);
      repeat (2) step(1'b1, 1'b0, $urandom, 1'b0);

      // ALU and branch decode.
      step(1'b1, 1'b1, mk_ir(5'd0, 5'd3, 5'd9), 1'b0);
      step(1'b1, 1'b1, mk_ir(5'd2, 5'($urandom), 5'($urandom)), 1'b0);
      step(1'b1, 1'b0, $urandom, 1'b0);

      // Single mult window.
      ir = mk_ir(5'd0, 5'd6, 5'd5);
      repeat (MC + 2) step(1'b1, 1'b1, ir, 1'b0);
      repeat (2) step(1'b1, 1'b0, $urandom, 1'b0);

      // Div then mult back-to-back.
      ir = mk_ir(5'd0, 5'd7, 5'd2);
      repeat (DC + 2) step(1'b1, 1'b1, ir, 1'b0);
      ir = mk_ir(5'd0, 5'd6, 5'd3);
      repeat (MC + 2) step(1'b1, 1'b1, ir, 1'b0);
      repeat (2) step(1'b1, 1'b0, $urandom, 1'b0);

      // Flush in the second BUSY cycle.
      ir = mk_ir(5'd0, 5'd6, 5'd4);
      step(1'b1, 1'b1, ir, 1'b0);
      step(1'b1, 1'b1, ir, 1'b0);
      step(1'b1, 1'b1, ir, 1'b1);
      repeat (MC + 2) step(1'b1, 1'b0, $urandom, 1'b0);

      // Asynchronous reset mid-window.
      ir = mk_ir(5'd0, 5'd7, 5'd6);
      step(1'b1, 1'b1, ir, 1'b0);
      step(1'b1, 1'b1, ir, 1'b0);
      rst_mid();
      step(1'b0, 1'b0, $urandom, 1'b0);
      repeat (DC + 3) step(1'b1, 1'b0, $urandom, 1'b0);

      // Randomised instruction stream; instructions are held while the model stalls.
      cur_ir = '0;
      cur_v  = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (!prev_stall) begin
            r = $urandom_range(0, 9);
            if (r < 4)      op = 5'd0;
            else if (r < 6) op = 5'd2;
            else if (r < 7) op = 5'd6;
            else            op = 5'($urandom_range(0, 31));
            if (op == 5'd0 && $urandom_range(0, 2) == 0)
               fn = ($urandom_range(0, 1) == 0) ? 5'd6 : 5'd7;
            else
               fn = 5'($urandom_range(0, 31));
            cur_ir = mk_ir(op, fn, 5'($urandom_range(0, 31)));
            cur_v  = ($urandom_range(0, 9) != 0);
         end
         step(1'b1, cur_v, cur_ir, ($urandom_range(0, 19) == 0));
      end

      @(posedge clock);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
